// File: rtl/waxi_loader.sv
// waxi_loader: AXI4 write-only master for single-beat word writes.
//
// Takes a valid/ready stream of (address, data, strobe) requests. Requests go
// through a small FIFO and are issued as strictly serialized AW -> W -> B
// transactions, with only one transaction outstanding at a time.
//
// Ports:
//   axi_clk_i, rst_i        - clock; asynchronous active-high reset
//   req_*                   - request stream (valid/ready, addr, data, strb)
//   m_axi_aw*/w*/b*         - AXI4 write address, write data and response channels
//   busy_o                  - FIFO non-empty or a transaction in progress
//   done_cnt_o              - completed transactions (wrapping)
//   err_o, timeout_o        - sticky error / timeout flags, cleared by err_clr_i
//
// Optional feature: define AXI_WR_TIMEOUT_EN to enable a per-phase watchdog of
// TimeoutCycles cycles. Without it the FSM waits indefinitely and timeout_o is 0.

module waxi_loader #(
    parameter int unsigned ByteLength    = 8,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned IdWidth       = 8,
    parameter int unsigned TxnId         = 0,
    parameter int unsigned FifoDepth     = 4,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                            axi_clk_i,
    input  logic                            rst_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [AddrWidth-1:0]            req_addr_i,
    input  logic [DataWidth-1:0]            req_data_i,
    input  logic [DataWidth/ByteLength-1:0] req_strb_i,
    output logic [IdWidth-1:0]              m_axi_awid_o,
    output logic [AddrWidth-1:0]            m_axi_awaddr_o,
    output logic [7:0]                      m_axi_awlen_o,
    output logic [2:0]                      m_axi_awsize_o,
    output logic [1:0]                      m_axi_awburst_o,
    output logic [1:0]                      m_axi_awlock_o,
    output logic [3:0]                      m_axi_awcache_o,
    output logic [2:0]                      m_axi_awprot_o,
    output logic                            m_axi_awvalid_o,
    input  logic                            m_axi_awready_i,
    output logic [DataWidth-1:0]            m_axi_wdata_o,
    output logic [DataWidth/ByteLength-1:0] m_axi_wstrb_o,
    output logic                            m_axi_wlast_o,
    output logic                            m_axi_wvalid_o,
    input  logic                            m_axi_wready_i,
    input  logic [IdWidth-1:0]              m_axi_bid_i,
    input  logic [1:0]                      m_axi_bresp_i,
    input  logic                            m_axi_bvalid_i,
    output logic                            m_axi_bready_o,
    output logic                            busy_o,
    output logic [31:0]                     done_cnt_o,
    output logic                            err_o,
    output logic                            timeout_o,
    input  logic                            err_clr_i
);
    localparam int unsigned StrbWidth = DataWidth / ByteLength;
    localparam int unsigned PtrWidth  = $clog2(FifoDepth);
    localparam int unsigned EntWidth  = AddrWidth + DataWidth + StrbWidth;

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    state_e                 state_q, state_d;
    logic [EntWidth-1:0]    fifo_mem_q [FifoDepth];
    logic [PtrWidth-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrWidth:0]      count_q, count_d;
    logic                   push, pop, fifo_full, fifo_empty;
    logic [AddrWidth-1:0]   head_addr, awaddr_q, awaddr_d;
    logic [DataWidth-1:0]   head_data, wdata_q, wdata_d;
    logic [StrbWidth-1:0]   head_strb, wstrb_q, wstrb_d;
    logic                   awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic [31:0]            done_cnt_q, done_cnt_d;
    logic                   err_q, err_d;
    logic                   bus_err, tmo_hit;

`ifdef AXI_WR_TIMEOUT_EN
    localparam logic [31:0] TmoLast = 32'(TimeoutCycles - 1);
    logic [31:0] tmo_q, tmo_d;
    logic        timeout_q, timeout_d;
`else
    logic unused_tmo;
    assign unused_tmo = ^32'(TimeoutCycles);
`endif

    // Request FIFO
    assign fifo_full   = (count_q == (PtrWidth+1)'(FifoDepth));
    assign fifo_empty  = (count_q == '0);
    // Held low during reset so no request is accepted while the block is cleared.
    assign req_ready_o = !fifo_full && !rst_i;
    assign push        = req_valid_i && req_ready_o;
    assign {head_addr, head_data, head_strb} = fifo_mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrWidth'(1);
        if (push && !pop)      count_d = count_q + (PtrWidth+1)'(1);
        else if (!push && pop) count_d = count_q - (PtrWidth+1)'(1);
    end

    always_ff @(posedge axi_clk_i) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {req_addr_i, req_data_i, req_strb_i};
    end

    // Transaction FSM
    always_comb begin
        state_d    = state_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        done_cnt_d = done_cnt_q;
        pop        = 1'b0;
        bus_err    = 1'b0;
        tmo_hit    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    awaddr_d  = head_addr;
                    wdata_d   = head_data;
                    wstrb_d   = head_strb;
                    awvalid_d = 1'b1;
                    state_d   = StAddr;
                end
            end
            StAddr: begin
                if (awvalid_q && m_axi_awready_i) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    state_d   = StData;
                end
            end
            StData: begin
                if (wvalid_q && m_axi_wready_i) begin
                    wvalid_d = 1'b0;
                    bready_d = 1'b1;
                    state_d  = StResp;
                end
            end
            StResp: begin
                if (bready_q && m_axi_bvalid_i) begin
                    bready_d   = 1'b0;
                    done_cnt_d = done_cnt_q + 32'd1;
                    bus_err    = (m_axi_bresp_i != 2'b00) || (m_axi_bid_i != IdWidth'(TxnId));
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef AXI_WR_TIMEOUT_EN
        // Counter restarts on every state entry; a phase that stalls for the
        // full limit is abandoned without counting it.
        tmo_d = '0;
        if (state_q != StIdle && state_d == state_q) begin
            if (tmo_q == TmoLast) begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                tmo_hit   = 1'b1;
                state_d   = StIdle;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
        timeout_d = timeout_q;
        if (err_clr_i) timeout_d = 1'b0;
        if (tmo_hit)   timeout_d = 1'b1;
`endif

        // A new error wins over a simultaneous clear.
        err_d = err_q;
        if (err_clr_i)          err_d = 1'b0;
        if (bus_err || tmo_hit) err_d = 1'b1;
    end

    always_ff @(posedge axi_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            done_cnt_q <= '0;
            err_q      <= 1'b0;
`ifdef AXI_WR_TIMEOUT_EN
            tmo_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            done_cnt_q <= done_cnt_d;
            err_q      <= err_d;
`ifdef AXI_WR_TIMEOUT_EN
            tmo_q      <= tmo_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

`ifdef AXI_WR_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign m_axi_awid_o    = IdWidth'(TxnId);
    assign m_axi_awaddr_o  = awaddr_q;
    assign m_axi_awlen_o   = 8'd0;
    assign m_axi_awsize_o  = 3'($clog2(StrbWidth));
    assign m_axi_awburst_o = 2'b01;
    assign m_axi_awlock_o  = 2'b00;
    assign m_axi_awcache_o = 4'b0000;
    assign m_axi_awprot_o  = 3'b000;
    assign m_axi_awvalid_o = awvalid_q;
    assign m_axi_wdata_o   = wdata_q;
    assign m_axi_wstrb_o   = wstrb_q;
    assign m_axi_wlast_o   = 1'b1;
    assign m_axi_wvalid_o  = wvalid_q;
    assign m_axi_bready_o  = bready_q;
    assign busy_o          = !fifo_empty || (state_q != StIdle);
    assign done_cnt_o      = done_cnt_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_waxi_loader.sv
// Testbench for waxi_loader: random requests, scoreboard of expected AXI
// writes, a slave model with configurable stalls/responses, and a monitor that
// checks every beat, the completion count and the sticky flags.
module tb_waxi_loader;
    localparam int unsigned Tmo = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } req_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [31:0] req_addr = '0, req_data = '0;
    logic [3:0]  req_strb = '0;
    logic [7:0]  awid, awlen;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock;
    logic [3:0]  awcache, wstrb;
    logic [31:0] awaddr, wdata, done_cnt;
    logic        awvalid, awready = 1'b0, wlast, wvalid, wready = 1'b0;
    logic [7:0]  bid = '0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0, bready, busy, err, timeout, err_clr = 1'b0;

    // slave configuration
    logic       aw_hold = 1'b0, w_hold = 1'b0, rand_mode = 1'b0, no_bresp = 1'b0;
    logic [1:0] cfg_bresp = 2'b00;
    logic [7:0] cfg_bid = 8'h00;

    int   n_cmp = 0, n_fail = 0;
    req_t exp_q[$];
    req_t cur;
    logic aw_done = 1'b0;
    logic [31:0] model_cnt = '0;
    logic model_err = 1'b0, model_tmo = 1'b0;
    int   wait_cnt = 0;
    int   total = 0;

    waxi_loader #(
        .ByteLength   (8),
        .AddrWidth    (32),
        .DataWidth    (32),
        .IdWidth      (8),
        .TxnId        (0),
        .FifoDepth    (4),
        .TimeoutCycles(Tmo)
    ) dut (
        .axi_clk_i      (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_addr_i     (req_addr),
        .req_data_i     (req_data),
        .req_strb_i     (req_strb),
        .m_axi_awid_o   (awid),
        .m_axi_awaddr_o (awaddr),
        .m_axi_awlen_o  (awlen),
        .m_axi_awsize_o (awsize),
        .m_axi_awburst_o(awburst),
        .m_axi_awlock_o (awlock),
        .m_axi_awcache_o(awcache),
        .m_axi_awprot_o (awprot),
        .m_axi_awvalid_o(awvalid),
        .m_axi_awready_i(awready),
        .m_axi_wdata_o  (wdata),
        .m_axi_wstrb_o  (wstrb),
        .m_axi_wlast_o  (wlast),
        .m_axi_wvalid_o (wvalid),
        .m_axi_wready_i (wready),
        .m_axi_bid_i    (bid),
        .m_axi_bresp_i  (bresp),
        .m_axi_bvalid_i (bvalid),
        .m_axi_bready_o (bready),
        .busy_o         (busy),
        .done_cnt_o     (done_cnt),
        .err_o          (err),
        .timeout_o      (timeout),
        .err_clr_i      (err_clr)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endfunction

    // Slave: samples handshakes at negedge, drives its outputs just after posedge.
    logic s_w_hs, s_b_hs, b_wait = 1'b0;
    int   b_dly = 0;
    always begin
        @(negedge clk);
        s_w_hs = wvalid && wready;
        s_b_hs = bvalid && bready;
        @(posedge clk);
        #1;
        if (rst) begin
            bvalid = 1'b0;
            b_wait = 1'b0;
        end else begin
            if (s_b_hs) bvalid = 1'b0;
            if (s_w_hs) begin
                b_wait = 1'b1;
                b_dly  = rand_mode ? int'($urandom_range(0, 2)) : 0;
            end
            if (no_bresp) b_wait = 1'b0;
            if (b_wait) begin
                if (b_dly == 0) begin
                    bvalid = 1'b1;
                    bresp  = cfg_bresp;
                    bid    = cfg_bid;
                    b_wait = 1'b0;
                end else begin
                    b_dly--;
                end
            end
        end
        awready = !aw_hold && (!rand_mode || $urandom_range(0, 3) != 0);
        wready  = !w_hold && (!rand_mode || $urandom_range(0, 3) != 0);
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic b_hs, b_err, tmo_ev;
        if (rst) begin
            exp_q.delete();
            aw_done   = 1'b0;
            model_cnt = '0;
            model_err = 1'b0;
            model_tmo = 1'b0;
            wait_cnt  = 0;
        end else begin
            chk("done_cnt", done_cnt, model_cnt);
            chk("err_o", err, model_err);
            chk("timeout_o", timeout, model_tmo);
            if (wvalid) begin
                chk("w_after_aw", aw_done, 1);
                chk("wlast", wlast, 1);
                chk("wdata", wdata, cur.data);
                chk("wstrb", wstrb, cur.strb);
                if (wready) aw_done = 1'b0;
            end
            if (awvalid) begin
                chk("aw_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("awaddr", awaddr, exp_q[0].addr);
                if (awready) begin
                    chk("aw_const", {awid, awlen, awsize, awburst, awlock, awcache, awprot},
                        {8'h00, 8'h00, 3'd2, 2'b01, 2'b00, 4'h0, 3'h0});
                    if (exp_q.size() != 0) cur = exp_q.pop_front();
                    aw_done = 1'b1;
                end
            end
            b_hs   = bvalid && bready;
            b_err  = b_hs && (bresp != 2'b00 || bid != 8'h00);
            tmo_ev = 1'b0;
`ifdef AXI_WR_TIMEOUT_EN
            if ((awvalid || wvalid || bready) &&
                !((awvalid && awready) || (wvalid && wready) || b_hs)) begin
                wait_cnt++;
                if (wait_cnt == Tmo) begin
                    tmo_ev   = 1'b1;
                    wait_cnt = 0;
                    if (awvalid && exp_q.size() != 0) void'(exp_q.pop_front());
                    aw_done = 1'b0;
                end
            end else begin
                wait_cnt = 0;
            end
`endif
            if (err_clr) begin
                model_err = 1'b0;
                model_tmo = 1'b0;
            end
            if (b_hs)  model_cnt = model_cnt + 32'd1;
            if (b_err) model_err = 1'b1;
            if (tmo_ev) begin
                model_err = 1'b1;
                model_tmo = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int   g = 0;
        logic acc = 1'b0;
        req_addr  = a;
        req_data  = d;
        req_strb  = s;
        req_valid = 1'b1;
        while (!acc && g < 200) begin
            @(negedge clk);
            if (req_ready) begin
                acc = 1'b1;
                exp_q.push_back('{addr: a, data: d, strb: s});
                total++;
            end
            g++;
            step();
        end
        if (!acc) chk("push_accept", 0, 1);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (busy && g < 1000);
        chk("idle_reached", busy, 0);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    initial begin
        int n;
        int g;
        #2;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_valids", {awvalid, wvalid, bready}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_cnt, 0);
        chk("rst_flags", {err, timeout}, 0);
        chk("rst_payload", {awaddr, wdata, wstrb}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", req_ready, 1);

        // Single write with latency check
        step();
        push(32'h10, 32'hDEAD_BEEF, 4'hF);
        chk("awvalid_e0", awvalid, 0);
        step();
        chk("awvalid_e1", awvalid, 1);
        wait_idle();
        chk("single_done", done_cnt, 1);
        chk("single_err", err, 0);

        // FIFO fill: one in flight plus FifoDepth queued
        step();
        aw_hold = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            push(32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'(i + 1));
            if (i == 3) chk("ready_after_4", req_ready, 1);
            if (i == 4) chk("ready_after_5", req_ready, 0);
        end
        aw_hold = 1'b0;
        wait_idle();
        chk("fill_done", done_cnt, 32'(total));

        // Random traffic with stalls
        step();
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push({$urandom(), 2'b00} & 32'hFFFF_FFFC, $urandom(), 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) step();
        end
        wait_idle();
        chk("rand_done", done_cnt, 32'(total));
        rand_mode = 1'b0;

        // Error responses
        step();
        cfg_bresp = 2'b10;
        push(32'h200, 32'h1234_5678, 4'h3);
        wait_idle();
        chk("bresp_err", err, 1);
        chk("bresp_counted", done_cnt, 32'(total));
        step();
        clear_err();
        chk("err_cleared", err, 0);
        cfg_bresp = 2'b00;
        cfg_bid   = 8'h05;
        push(32'h204, 32'h0, 4'h1);
        wait_idle();
        chk("bid_err", err, 1);
        step();
        clear_err();
        cfg_bid   = 8'h00;
        // clear coincides with the failing B handshake
        cfg_bresp = 2'b11;
        push(32'h208, 32'hFFFF_0000, 4'hC);
        repeat (3) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        wait_idle();
        chk("err_wins_clear", err, 1);
        step();
        clear_err();
        cfg_bresp = 2'b00;

`ifdef AXI_WR_TIMEOUT_EN
        // Response never arrives
        no_bresp = 1'b1;
        n = 0;
        push(32'h300, 32'h5555_AAAA, 4'hF);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!bready && g < 50);
        chk("bready_seen", bready, 1);
        n = 1;
        g = 0;
        while (g < 100) begin
            @(negedge clk);
            g++;
            if (bready) n++;
            else break;
        end
        chk("bready_cycles", n, Tmo);
        chk("tmo_flag", timeout, 1);
        chk("tmo_err", err, 1);
        chk("tmo_no_count", done_cnt, 32'(total - 1));
        no_bresp = 1'b0;
        step();
        clear_err();
        chk("tmo_cleared", timeout, 0);
`endif

        // Asynchronous reset while the W phase is stalled
        step();
        w_hold = 1'b1;
        push(32'h400, 32'hCAFE_0001, 4'hF);
        push(32'h404, 32'hCAFE_0002, 4'hF);
        push(32'h408, 32'hCAFE_0003, 4'hF);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!wvalid && g < 20);
        chk("wvalid_before_rst", wvalid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_valids", {awvalid, wvalid, bready}, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done_cnt, 0);
        chk("rst_mid_ready", req_ready, 0);
        chk("rst_mid_err", err, 0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        w_hold = 1'b0;
        #1;
        chk("ready_after_rst2", req_ready, 1);
        step();
        push(32'h500, 32'h0BAD_F00D, 4'h6);
        wait_idle();
        chk("post_rst_done", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
